// File: rtl/seq_mult_pkg.sv
// Shared types for the sequential-multiplier issue front-end.
package seq_mult_pkg;

  localparam int DEFAULT_WIDTH = 16;

  typedef enum logic [1:0] {
    IDLE,
    LAUNCH,
    WAIT,
    HOLD
  } issue_state_t;

  typedef struct packed {
    logic [DEFAULT_WIDTH-1:0] a;
    logic [DEFAULT_WIDTH-1:0] b;
  } operand_pair_t;

endpackage

// File: rtl/mult_operand_fifo.sv
// Operand-pair FIFO with first-word-fall-through head.
// Full and empty are derived from the occupancy count.
module mult_operand_fifo
  import seq_mult_pkg::*;
#(
  parameter int  DEPTH = 4,
  parameter type T     = operand_pair_t
) (
  input  logic                     i_clk,
  input  logic                     i_rst,
  input  logic                     i_push,
  input  T                         i_data,
  input  logic                     i_pop,
  output T                         o_head,
  output logic [$clog2(DEPTH):0]   o_count,
  output logic                     o_full,
  output logic                     o_empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  T              r_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [CW-1:0] r_count;
  logic          w_do_push;
  logic          w_do_pop;

  assign o_full    = (r_count == CW'(DEPTH));
  assign o_empty   = (r_count == '0);
  // A full FIFO refuses the push even if the head is popped in the same cycle.
  assign w_do_push = i_push & ~o_full;
  assign w_do_pop  = i_pop & ~o_empty;
  assign o_head    = r_mem[r_rd_ptr];
  assign o_count   = r_count;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge i_clk) begin
    if (w_do_push) r_mem[r_wr_ptr] <= i_data;
  end

endmodule

// File: rtl/seq_mult_issue.sv
// Issues buffered operand pairs one at a time to the sequential multiplier and
// returns products on a valid/ready stream, with zero shortcut and hang timeout.
module seq_mult_issue
  import seq_mult_pkg::*;
#(
  parameter int WIDTH   = DEFAULT_WIDTH,
  parameter int DEPTH   = 4,
  parameter int TIMEOUT = 64
) (
  input  logic                     i_clk,
  input  logic                     i_reset,
  input  logic                     i_in_valid,
  output logic                     o_in_ready,
  input  logic [WIDTH-1:0]         i_in_a,
  input  logic [WIDTH-1:0]         i_in_b,
  output logic                     o_mult_start,
  output logic [WIDTH-1:0]         o_mult_multiplicand,
  output logic [WIDTH-1:0]         o_mult_multiplier,
  input  logic                     i_mult_done,
  input  logic [2*WIDTH-1:0]       i_mult_product,
  output logic                     o_out_valid,
  input  logic                     i_out_ready,
  output logic [2*WIDTH-1:0]       o_out_product,
  output logic                     o_busy,
  output logic                     o_timeout_err,
  output logic [$clog2(DEPTH):0]   o_fifo_count
);

  localparam int CW = $clog2(DEPTH) + 1;
  localparam int TW = $clog2(TIMEOUT);

  typedef struct packed {
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
  } pair_t;

  issue_state_t     r_state;
  logic             r_mult_start;
  logic [WIDTH-1:0] r_op_a;
  logic [WIDTH-1:0] r_op_b;
  logic             r_out_valid;
  logic [2*WIDTH-1:0] r_out_product;
  logic             r_timeout_err;
  logic [TW-1:0]    r_wait_cnt;

  pair_t            w_in_pair;
  pair_t            w_head;
  logic             w_pop;
  logic             w_full;
  logic             w_empty;
  logic [CW-1:0]    w_count;

  assign w_in_pair = {i_in_a, i_in_b};
  assign w_pop     = (r_state == IDLE) && !w_empty;

  mult_operand_fifo #(
    .DEPTH (DEPTH),
    .T     (pair_t)
  ) u_fifo (
    .i_clk   (i_clk),
    .i_rst   (i_reset),
    .i_push  (i_in_valid),
    .i_data  (w_in_pair),
    .i_pop   (w_pop),
    .o_head  (w_head),
    .o_count (w_count),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_state       <= IDLE;
      r_mult_start  <= 1'b0;
      r_op_a        <= '0;
      r_op_b        <= '0;
      r_out_valid   <= 1'b0;
      r_out_product <= '0;
      r_timeout_err <= 1'b0;
      r_wait_cnt    <= '0;
    end else begin
      r_mult_start <= 1'b0;
      case (r_state)
        IDLE: begin
          if (!w_empty) begin
            r_op_a <= w_head.a;
            r_op_b <= w_head.b;
            if (w_head.a == '0 || w_head.b == '0) begin
              r_out_product <= '0;
              r_out_valid   <= 1'b1;
              r_state       <= HOLD;
            end else begin
              r_mult_start <= 1'b1;
              r_state      <= LAUNCH;
            end
          end
        end
        LAUNCH: begin
          r_wait_cnt <= '0;
          r_state    <= WAIT;
        end
        WAIT: begin
          if (i_mult_done) begin
            r_out_product <= i_mult_product;
            r_out_valid   <= 1'b1;
            r_state       <= HOLD;
          end else if (r_wait_cnt == TW'(TIMEOUT - 1)) begin
            // Hung multiplier: drop this pair and move on.
            r_timeout_err <= 1'b1;
            r_state       <= IDLE;
          end else begin
            r_wait_cnt <= r_wait_cnt + 1'b1;
          end
        end
        HOLD: begin
          if (i_out_ready) begin
            r_out_valid <= 1'b0;
            r_state     <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign o_in_ready          = !w_full;
  assign o_mult_start        = r_mult_start;
  assign o_mult_multiplicand = r_op_a;
  assign o_mult_multiplier   = r_op_b;
  assign o_out_valid         = r_out_valid;
  assign o_out_product       = r_out_product;
  assign o_busy              = (r_state != IDLE) || !w_empty;
  assign o_timeout_err       = r_timeout_err;
  assign o_fifo_count        = w_count;

endmodule

// File: tb/tb_seq_mult_issue.sv
// Scoreboard bench for seq_mult_issue with a behavioural multiplier model.
module tb_seq_mult_issue;

  logic        i_clk = 1'b0;
  logic        i_reset = 1'b1;
  logic        i_in_valid = 1'b0;
  logic        o_in_ready;
  logic [15:0] i_in_a = '0;
  logic [15:0] i_in_b = '0;
  logic        o_mult_start;
  logic [15:0] o_mult_multiplicand;
  logic [15:0] o_mult_multiplier;
  logic        i_mult_done = 1'b0;
  logic [31:0] i_mult_product = '0;
  logic        o_out_valid;
  logic        i_out_ready = 1'b0;
  logic [31:0] o_out_product;
  logic        o_busy;
  logic        o_timeout_err;
  logic [2:0]  o_fifo_count;

  int n_cmp = 0;
  int n_mis = 0;
  logic [31:0] sb_q[$];

  int n_start = 0;
  int cyc = 0;
  int last_start = 0;

  int          m_lat = 17;
  bit          m_enable = 1'b1;
  bit          m_hold = 1'b0;
  bit          m_busy = 1'b0;
  int          m_cnt = 0;
  logic [15:0] m_a = '0;
  logic [15:0] m_b = '0;

  seq_mult_issue dut (
    .i_clk               (i_clk),
    .i_reset             (i_reset),
    .i_in_valid          (i_in_valid),
    .o_in_ready          (o_in_ready),
    .i_in_a              (i_in_a),
    .i_in_b              (i_in_b),
    .o_mult_start        (o_mult_start),
    .o_mult_multiplicand (o_mult_multiplicand),
    .o_mult_multiplier   (o_mult_multiplier),
    .i_mult_done         (i_mult_done),
    .i_mult_product      (i_mult_product),
    .o_out_valid         (o_out_valid),
    .i_out_ready         (i_out_ready),
    .o_out_product       (o_out_product),
    .o_busy              (o_busy),
    .o_timeout_err       (o_timeout_err),
    .o_fifo_count        (o_fifo_count)
  );

  always #5 i_clk = ~i_clk;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_mis++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Multiplier model: done strobe m_lat cycles after the start pulse.
  always @(negedge i_clk) begin
    if (i_reset) begin
      m_busy      = 1'b0;
      i_mult_done = 1'b0;
    end else begin
      i_mult_done = 1'b0;
      if (m_busy && !m_hold) begin
        if (m_cnt <= 1) begin
          i_mult_done    = 1'b1;
          i_mult_product = 32'(m_a) * 32'(m_b);
          m_busy         = 1'b0;
        end else begin
          m_cnt--;
        end
      end
      if (o_mult_start && m_enable) begin
        m_busy = 1'b1;
        m_cnt  = m_lat;
        m_a    = o_mult_multiplicand;
        m_b    = o_mult_multiplier;
      end
    end
  end

  always @(negedge i_clk) begin
    #1;
    cyc++;
    if (o_mult_start) begin
      n_start++;
      last_start = cyc;
    end
    if (!i_reset && o_out_valid && i_out_ready) begin
      if (sb_q.size() == 0) check_val("sb_extra_out", {63'd0, o_out_valid}, 64'd0);
      else check_val("out_product", {32'd0, o_out_product}, {32'd0, sb_q.pop_front()});
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic push_pair(input logic [15:0] a, input logic [15:0] b,
                           input bit has_out, input logic [31:0] exp);
    logic ok;
    ok = 1'b0;
    @(negedge i_clk);
    i_in_valid = 1'b1;
    i_in_a     = a;
    i_in_b     = b;
    for (int i = 0; i < 300; i++) begin
      ok = o_in_ready;
      @(posedge i_clk);
      if (ok) break;
    end
    check_val("push_accept", {63'd0, ok}, 64'd1);
    if (has_out) sb_q.push_back(exp);
  endtask

  task automatic idle_in();
    @(negedge i_clk);
    i_in_valid = 1'b0;
  endtask

  task automatic drain(input string tag, input int max_cyc);
    for (int i = 0; i < max_cyc; i++) begin
      @(negedge i_clk);
      #2;
      if (sb_q.size() == 0 && !o_busy && !o_out_valid) break;
    end
    check_val({tag, "_sb_left"}, 64'(sb_q.size()), 64'd0);
    check_val({tag, "_busy"}, {63'd0, o_busy}, 64'd0);
  endtask

  initial begin
    int s0;
    int stray;

    repeat (3) @(negedge i_clk);
    check_val("rst_in_ready", {63'd0, o_in_ready}, 64'd1);
    check_val("rst_out_valid", {63'd0, o_out_valid}, 64'd0);
    check_val("rst_mult_start", {63'd0, o_mult_start}, 64'd0);
    check_val("rst_busy", {63'd0, o_busy}, 64'd0);
    check_val("rst_count", 64'(o_fifo_count), 64'd0);
    check_val("rst_terr", {63'd0, o_timeout_err}, 64'd0);
    check_val("rst_product", 64'(o_out_product), 64'd0);
    i_reset = 1'b0;
    repeat (2) @(negedge i_clk);

    // Single pair with 17-cycle multiplier latency; consumer stalls first.
    s0 = n_start;
    push_pair(16'd20, 16'd30, 1'b1, 32'd600);
    idle_in();
    for (int i = 0; i < 100; i++) begin
      @(negedge i_clk);
      #2;
      if (o_out_valid) break;
    end
    check_val("t1_valid", {63'd0, o_out_valid}, 64'd1);
    check_val("t1_latency", 64'(cyc - last_start), 64'd18);
    check_val("t1_product", 64'(o_out_product), 64'd600);
    repeat (3) @(negedge i_clk);
    check_val("t1_valid_held", {63'd0, o_out_valid}, 64'd1);
    check_val("t1_opa_held", 64'(o_mult_multiplicand), 64'd20);
    i_out_ready = 1'b1;
    drain("t1", 50);
    check_val("t1_starts", 64'(n_start - s0), 64'd1);

    push_pair(16'hFFFF, 16'hFFFF, 1'b1, 32'hFFFE0001);
    idle_in();
    drain("t2", 100);

    // Zero operand: no start pulse, result one edge after acceptance.
    i_out_ready = 1'b0;
    s0 = n_start;
    push_pair(16'd0, 16'h1234, 1'b1, 32'd0);
    @(negedge i_clk);
    i_in_valid = 1'b0;
    check_val("t3_valid_e0", {63'd0, o_out_valid}, 64'd0);
    @(posedge i_clk);
    #1;
    check_val("t3_valid_e1", {63'd0, o_out_valid}, 64'd1);
    check_val("t3_product", 64'(o_out_product), 64'd0);
    i_out_ready = 1'b1;
    drain("t3", 20);
    check_val("t3_starts", 64'(n_start - s0), 64'd0);

    // Fill the FIFO while the multiplier is held and the consumer stalls.
    i_out_ready = 1'b0;
    m_hold      = 1'b1;
    s0 = n_start;
    push_pair(16'd3, 16'd4, 1'b1, 32'd12);
    push_pair(16'd5, 16'd6, 1'b1, 32'd30);
    push_pair(16'd7, 16'd8, 1'b1, 32'd56);
    push_pair(16'd9, 16'd10, 1'b1, 32'd90);
    push_pair(16'd11, 16'd12, 1'b1, 32'd132);
    @(negedge i_clk);
    i_in_a = 16'd13;
    i_in_b = 16'd14;
    check_val("t4_count_full", 64'(o_fifo_count), 64'd4);
    check_val("t4_in_ready", {63'd0, o_in_ready}, 64'd0);
    @(negedge i_clk);
    i_in_valid = 1'b0;
    check_val("t4_no_push_full", 64'(o_fifo_count), 64'd4);
    m_hold      = 1'b0;
    i_out_ready = 1'b1;
    drain("t4", 1000);
    check_val("t4_starts", 64'(n_start - s0), 64'd5);

    // Hung multiplier: timeout after 64 WAIT cycles, then normal service.
    m_enable = 1'b0;
    push_pair(16'd4, 16'd5, 1'b0, 32'd0);
    idle_in();
    for (int i = 0; i < 200; i++) begin
      @(negedge i_clk);
      #2;
      if (o_timeout_err) break;
    end
    check_val("t5_terr", {63'd0, o_timeout_err}, 64'd1);
    check_val("t5_wait_len", 64'(cyc - last_start), 64'd65);
    check_val("t5_idle", {63'd0, o_busy}, 64'd0);
    check_val("t5_no_valid", {63'd0, o_out_valid}, 64'd0);
    m_enable = 1'b1;
    push_pair(16'd2, 16'd3, 1'b1, 32'd6);
    idle_in();
    drain("t5", 100);
    check_val("t5_terr_sticky", {63'd0, o_timeout_err}, 64'd1);

    // Reset while waiting on the multiplier with a pair still queued.
    m_enable    = 1'b0;
    i_out_ready = 1'b1;
    push_pair(16'd6, 16'd7, 1'b0, 32'd0);
    push_pair(16'd8, 16'd9, 1'b0, 32'd0);
    idle_in();
    repeat (4) @(negedge i_clk);
    check_val("t6_pre_count", 64'(o_fifo_count), 64'd1);
    i_reset = 1'b1;
    #1;
    check_val("t6_count", 64'(o_fifo_count), 64'd0);
    check_val("t6_busy", {63'd0, o_busy}, 64'd0);
    check_val("t6_in_ready", {63'd0, o_in_ready}, 64'd1);
    check_val("t6_terr", {63'd0, o_timeout_err}, 64'd0);
    check_val("t6_opa", 64'(o_mult_multiplicand), 64'd0);
    check_val("t6_start", {63'd0, o_mult_start}, 64'd0);
    m_enable = 1'b1;
    repeat (3) @(negedge i_clk);
    i_reset = 1'b0;
    s0    = n_start;
    stray = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge i_clk);
      #2;
      if (o_out_valid) stray++;
    end
    check_val("t6_stray_valid", 64'(stray), 64'd0);
    check_val("t6_stray_start", 64'(n_start - s0), 64'd0);
    check_val("end_sb_empty", 64'(sb_q.size()), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
